phase1_sequencer: RTL and testbench
===================================

# phase1_sequencer

Sequences the four Phase-1 puzzle blocks, indices 0–3, with puzzle 3 being the final-click puzzle. Only one puzzle is enabled at a time, in fixed order. The block confirms each puzzle's `clear`, holds briefly on the solved puzzle, then advances, and enforces one phase-wide time limit. It is the single owner of the shared 7-segment bus and the motor pulse line, muxing them from whichever puzzle is active.

## Interface
Parameters:
- `HOLD_CYCLES`, default 50_000_000 — dwell cycles after a clear before advancing; must be ≥ 1.
- `TIME_LIMIT`, default 32'd3_000_000_000 — phase budget in cycles; must be ≥ 1.
- `DONE_PATTERN`, default 32'h0000_0000 — display value in DONE.
- `FAIL_PATTERN`, default 32'hEEEE_EEEE — display value in FAIL.

Ports:
- `clk`  in  1  — system clock.
- `rst_n`  in  1  — asynchronous, active-low reset.
- `start`  in  1  — single-cycle pulse; begins the phase.
- `abort`  in  1  — level; returns to IDLE.
- `puzzle_clear`  in  4  — `clear` from puzzles 0..3.
- `puzzle_motor`  in  4  — `motor_pulse` from puzzles 0..3.
- `puzzle_seg`  in  128  — `seg_display` of puzzle k on bits [32k+31:32k].
- `puzzle_enable`  out  4  — one-hot `enable` to puzzles; all zero when none is active.
- `seg_display`  out  32  — muxed display, registered.
- `motor_pulse`  out  1  — muxed motor pulse, registered.
- `stage`  out  2  — index of the active or last-active puzzle.
- `phase_done`  out  1  — level, high in DONE.
- `phase_fail`  out  1  — level, high in FAIL.

## Operation
- States: IDLE, RUN, HOLD, DONE, FAIL.
- Reset values: state IDLE, `stage` 0, timer 0, hold counter 0, `puzzle_enable` 0, `seg_display` 32'hFFFF_FFFF (all blank), `motor_pulse` 0, `phase_done` 0, `phase_fail` 0.
- **IDLE:**
  - All enables low; display 32'hFFFF_FFFF.
  - `start` → RUN with `stage` = 0 and timer = 0.
- **RUN:**
  - `puzzle_enable` = 1 << `stage`; timer increments by 1 each cycle.
  - `puzzle_clear[stage]` = 1 → HOLD with hold counter = 0.
  - Otherwise, timer == TIME_LIMIT−1 → FAIL.
- **HOLD:**
  - Enable stays asserted so the puzzle keeps showing its final count; timer is frozen.
  - Hold counter == HOLD_CYCLES−1 and `stage` < 3 → RUN with `stage`+1. The enable moves one-hot to the next puzzle in the same cycle; the previous puzzle sees `enable` low, which self-resets it.
  - Hold counter == HOLD_CYCLES−1 and `stage` == 3 → DONE.
- **DONE / FAIL:**
  - Enables are 0; display is DONE_PATTERN or FAIL_PATTERN; the status flag is high.
  - `start` → RUN from `stage` 0 with timer cleared.
- **`abort`** (highest priority, any state): → IDLE next cycle; enables 0; counters cleared; `stage` 0.
- **Ignored inputs:**
  - `start` while in RUN or HOLD.
  - `puzzle_clear` bits other than `[stage]`.
  - `puzzle_motor` bits other than `[stage]`.
- **Same-cycle conflicts:**
  - Clear and timeout in the same cycle: the clear wins and the FSM enters HOLD.
  - `abort` and `start` in the same cycle: `abort` wins.
- **Widths:**
  - Timer and hold counter are 32 bits and never wrap, because they stop at their terminal count.
  - `stage` increments only from 0–2, so it never wraps.

## Timing
- `puzzle_enable`, `stage`, `phase_done` and `phase_fail` are registered from state and change on the clock edge of the transition.
- `seg_display` and `motor_pulse` are registered, one cycle behind the input mux:
  - In RUN/HOLD: `seg_display` = `puzzle_seg` slice of `stage`.
  - In RUN/HOLD: `motor_pulse` = `puzzle_motor[stage]`.
  - Otherwise `motor_pulse` is 0.
  - A puzzle's motor pulse at cycle t appears at t+1, and exactly one output pulse is produced per input pulse.
- RUN→HOLD entry: one cycle after `puzzle_clear[stage]` is sampled high.
- HOLD length: exactly HOLD_CYCLES cycles.
- Timeout: FAIL is entered TIME_LIMIT RUN-cycles after `start`; HOLD cycles are not counted.
- Asynchronous reset mid-RUN: all outputs go immediately to their reset values, with no glitch on `puzzle_enable`.

## Test plan
- **Reset:** Assert `rst_n`=0 mid-RUN → `puzzle_enable`=0, `seg_display`=32'hFFFF_FFFF, `phase_done`=`phase_fail`=0.
- **Full pass** (HOLD_CYCLES=4, TIME_LIMIT=1000):
  - Pulse `start`; raise `clear` of each puzzle in turn.
  - `puzzle_enable` must step 0001→0010→0100→1000, with exactly 4 HOLD cycles each.
  - `phase_done`=1 and `seg_display`=32'h0000_0000 at the end.
- **Timeout** (TIME_LIMIT=20, no clears): `phase_fail` rises exactly 20 cycles after `start`; `seg_display`=32'hEEEE_EEEE; `puzzle_enable`=0.
- **Stray inputs:**
  - In stage 1, pulse `puzzle_clear[3]` and `puzzle_motor[0]` → no state change and `motor_pulse` stays 0.
  - Pulse `puzzle_motor[1]` → `motor_pulse`=1 exactly one cycle later.
- **Priorities:**
  - Clear and timeout in the same cycle (TIME_LIMIT=10, clear at cycle 9) → HOLD, not FAIL.
  - `abort` during HOLD → IDLE, `stage`=0, enables 0.
- **Restart:** `start` in FAIL → RUN at stage 0 with the timer reset; the timeout then occurs a full TIME_LIMIT later.

Source files
------------

// File: rtl/phase1_sequencer.sv
// Phase-1 sequencer: enables the four Phase-1 puzzles one at a time in order,
// confirms each clear, dwells on the solved puzzle, then advances. It enforces a
// single phase-wide time budget and owns the shared display bus and motor line.
module phase1_sequencer #(
  parameter logic [31:0] HOLD_CYCLES  = 32'd50_000_000,
  parameter logic [31:0] TIME_LIMIT   = 32'd3_000_000_000,
  parameter logic [31:0] DONE_PATTERN = 32'h0000_0000,
  parameter logic [31:0] FAIL_PATTERN = 32'hEEEE_EEEE
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          abort,
  input  logic [3:0]    puzzle_clear,
  input  logic [3:0]    puzzle_motor,
  input  logic [127:0]  puzzle_seg,
  output logic [3:0]    puzzle_enable,
  output logic [31:0]   seg_display,
  output logic          motor_pulse,
  output logic [1:0]    stage,
  output logic          phase_done,
  output logic          phase_fail
);

  localparam logic [31:0] HOLD_LAST  = HOLD_CYCLES - 32'd1;
  localparam logic [31:0] TIME_LAST  = TIME_LIMIT - 32'd1;
  localparam logic [31:0] BLANK      = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_HOLD,
    S_DONE,
    S_FAIL
  } state_t;

  state_t      state;
  logic [31:0] timer;
  logic [31:0] hold_cnt;

  // Signals of the puzzle currently selected by stage
  logic        cur_clear;
  logic        cur_motor;
  logic [31:0] cur_seg;

  // Select the active puzzle's clear, motor pulse and display slice
  always_comb begin
    cur_clear = puzzle_clear[stage];
    cur_motor = puzzle_motor[stage];
    cur_seg   = puzzle_seg[{stage, 5'b0} +: 32];
  end

  // Phase FSM with registered enable/status outputs and the registered display/motor mux
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      stage         <= 2'd0;
      timer         <= 32'd0;
      hold_cnt      <= 32'd0;
      puzzle_enable <= 4'b0000;
      seg_display   <= BLANK;
      motor_pulse   <= 1'b0;
      phase_done    <= 1'b0;
      phase_fail    <= 1'b0;
    end else begin
      // Output mux lags the puzzle inputs by one cycle and follows the current state
      case (state)
        S_RUN, S_HOLD: begin
          seg_display <= cur_seg;
          motor_pulse <= cur_motor;
        end
        S_DONE: begin
          seg_display <= DONE_PATTERN;
          motor_pulse <= 1'b0;
        end
        S_FAIL: begin
          seg_display <= FAIL_PATTERN;
          motor_pulse <= 1'b0;
        end
        default: begin
          seg_display <= BLANK;
          motor_pulse <= 1'b0;
        end
      endcase

      if (abort) begin
        // Abort overrides everything, including a simultaneous start
        state         <= S_IDLE;
        stage         <= 2'd0;
        timer         <= 32'd0;
        hold_cnt      <= 32'd0;
        puzzle_enable <= 4'b0000;
        phase_done    <= 1'b0;
        phase_fail    <= 1'b0;
      end else begin
        case (state)
          S_IDLE, S_DONE, S_FAIL: begin
            if (start) begin
              state         <= S_RUN;
              stage         <= 2'd0;
              timer         <= 32'd0;
              hold_cnt      <= 32'd0;
              puzzle_enable <= 4'b0001;
              phase_done    <= 1'b0;
              phase_fail    <= 1'b0;
            end
          end

          S_RUN: begin
            if (cur_clear) begin
              // A clear beats a simultaneous timeout. The timer saturates at its
              // last value so the budget is exhausted on the next RUN cycle.
              state    <= S_HOLD;
              hold_cnt <= 32'd0;
              if (timer != TIME_LAST) begin
                timer <= timer + 32'd1;
              end
            end else if (timer == TIME_LAST) begin
              state         <= S_FAIL;
              puzzle_enable <= 4'b0000;
              phase_fail    <= 1'b1;
            end else begin
              timer <= timer + 32'd1;
            end
          end

          S_HOLD: begin
            // Enable stays on so the solved puzzle keeps its final display; timer frozen
            if (hold_cnt == HOLD_LAST) begin
              hold_cnt <= 32'd0;
              if (stage == 2'd3) begin
                state         <= S_DONE;
                puzzle_enable <= 4'b0000;
                phase_done    <= 1'b1;
              end else begin
                // Enable hops to the next puzzle; dropping the old enable resets that puzzle
                state         <= S_RUN;
                stage         <= stage + 2'd1;
                puzzle_enable <= puzzle_enable << 1;
              end
            end else begin
              hold_cnt <= hold_cnt + 32'd1;
            end
          end

          default: begin
            state         <= S_IDLE;
            stage         <= 2'd0;
            timer         <= 32'd0;
            hold_cnt      <= 32'd0;
            puzzle_enable <= 4'b0000;
            phase_done    <= 1'b0;
            phase_fail    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_phase1_sequencer.sv
// Testbench for phase1_sequencer: a per-cycle reference model predicts every
// registered output; a monitor pops predictions and compares them with the DUT.
module tb_phase1_sequencer;

  localparam int HOLD = 4;
  localparam int TL   = 20;
  localparam logic [31:0] DONE_PAT = 32'h0000_0000;
  localparam logic [31:0] FAIL_PAT = 32'hEEEE_EEEE;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         abort;
  logic [3:0]   puzzle_clear;
  logic [3:0]   puzzle_motor;
  logic [127:0] puzzle_seg;
  logic [3:0]   puzzle_enable;
  logic [31:0]  seg_display;
  logic         motor_pulse;
  logic [1:0]   stage;
  logic         phase_done;
  logic         phase_fail;

  phase1_sequencer #(
    .HOLD_CYCLES (32'd4),
    .TIME_LIMIT  (32'd20),
    .DONE_PATTERN(DONE_PAT),
    .FAIL_PATTERN(FAIL_PAT)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .abort        (abort),
    .puzzle_clear (puzzle_clear),
    .puzzle_motor (puzzle_motor),
    .puzzle_seg   (puzzle_seg),
    .puzzle_enable(puzzle_enable),
    .seg_display  (seg_display),
    .motor_pulse  (motor_pulse),
    .stage        (stage),
    .phase_done   (phase_done),
    .phase_fail   (phase_fail)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  en;
    logic [31:0] seg;
    logic        mot;
    logic [1:0]  stg;
    logic        dn;
    logic        fl;
  } obs_t;

  obs_t exp_q[$];
  int   n_cmp = 0;
  int   n_mis = 0;
  int   cyc   = 0;

  // Reference model: what the phase is doing, in plain terms
  localparam int M_IDLE = 0, M_PLAY = 1, M_DWELL = 2, M_WON = 3, M_LOST = 4;
  int m_mode;
  int m_stage;
  int m_used;      // RUN cycles consumed from the budget since start
  int m_dwell;     // HOLD cycles still to go

  task automatic model_reset();
    m_mode  = M_IDLE;
    m_stage = 0;
    m_used  = 0;
    m_dwell = 0;
  endtask

  // Advance the model by one clock with the inputs currently on the pins
  task automatic model_step(output obs_t e);
    logic [31:0] seg_e;
    logic        mot_e;
    if (m_mode == M_PLAY || m_mode == M_DWELL) begin
      seg_e = puzzle_seg[m_stage*32 +: 32];
      mot_e = puzzle_motor[m_stage];
    end else begin
      mot_e = 1'b0;
      seg_e = (m_mode == M_WON) ? DONE_PAT : (m_mode == M_LOST) ? FAIL_PAT : 32'hFFFF_FFFF;
    end
    if (abort) begin
      model_reset();
    end else if (m_mode == M_PLAY) begin
      m_used++;
      if (puzzle_clear[m_stage]) begin
        m_mode  = M_DWELL;
        m_dwell = HOLD;
      end else if (m_used >= TL) begin
        m_mode = M_LOST;
      end
    end else if (m_mode == M_DWELL) begin
      m_dwell--;
      if (m_dwell == 0) begin
        if (m_stage == 3) m_mode = M_WON;
        else begin
          m_stage++;
          m_mode = M_PLAY;
        end
      end
    end else if (start) begin
      m_mode  = M_PLAY;
      m_stage = 0;
      m_used  = 0;
    end
    e.en  = (m_mode == M_PLAY || m_mode == M_DWELL) ? 4'(1 << m_stage) : 4'b0000;
    e.seg = seg_e;
    e.mot = mot_e;
    e.stg = 2'(m_stage);
    e.dn  = (m_mode == M_WON);
    e.fl  = (m_mode == M_LOST);
  endtask

  // Drive one cycle of inputs and queue the predicted outputs for the next edge
  task automatic step(input logic st, input logic ab, input logic [3:0] clr, input logic [3:0] mot);
    obs_t e;
    @(negedge clk);
    start        = st;
    abort        = ab;
    puzzle_clear = clr;
    puzzle_motor = mot;
    puzzle_seg   = {$urandom, $urandom, $urandom, $urandom};
    model_step(e);
    exp_q.push_back(e);
  endtask

  task automatic idle_steps(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 4'b0000, 4'b0000);
  endtask

  task automatic check_reset_values(input string tag);
    obs_t a;
    obs_t r;
    a = {puzzle_enable, seg_display, motor_pulse, stage, phase_done, phase_fail};
    r = {4'b0000, 32'hFFFF_FFFF, 1'b0, 2'd0, 1'b0, 1'b0};
    n_cmp++;
    if (a !== r) begin
      n_mis++;
      $display("FAIL %s: got en=%b seg=%h mot=%b stg=%0d done=%b fail=%b, required en=%b seg=%h mot=%b stg=%0d done=%b fail=%b",
               tag, a.en, a.seg, a.mot, a.stg, a.dn, a.fl, r.en, r.seg, r.mot, r.stg, r.dn, r.fl);
    end
  endtask

  // Asynchronous reset asserted between clock edges, checked before the next edge
  task automatic mid_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_values("async_reset");
    start = 1'b0; abort = 1'b0; puzzle_clear = 4'b0; puzzle_motor = 4'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  // Monitor: compare every registered output against the queued prediction
  always @(posedge clk) begin
    obs_t e;
    obs_t a;
    #1;
    cyc++;
    if (rst_n && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {puzzle_enable, seg_display, motor_pulse, stage, phase_done, phase_fail};
      n_cmp++;
      if (a !== e) begin
        n_mis++;
        $display("FAIL outputs@cyc%0d: got en=%b seg=%h mot=%b stg=%0d done=%b fail=%b, required en=%b seg=%h mot=%b stg=%0d done=%b fail=%b",
                 cyc, a.en, a.seg, a.mot, a.stg, a.dn, a.fl, e.en, e.seg, e.mot, e.stg, e.dn, e.fl);
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    start = 1'b0; abort = 1'b0;
    puzzle_clear = 4'b0; puzzle_motor = 4'b0; puzzle_seg = '0;
    model_reset();
    #12;
    check_reset_values("power_on_reset");
    @(negedge clk);
    rst_n = 1'b1;
    idle_steps(2);

    // Full pass: each puzzle clears on its second RUN cycle
    step(1'b1, 1'b0, 4'b0000, 4'b0000);
    for (int k = 0; k < 4; k++) begin
      step(1'b0, 1'b0, 4'b0000, 4'($urandom_range(0, 15)));
      step(1'b0, 1'b0, 4'(1 << k), 4'($urandom_range(0, 15)));
      for (int h = 0; h < HOLD; h++) step(1'b0, 1'b0, 4'b0000, 4'($urandom_range(0, 15)));
    end
    idle_steps(3);

    // Timeout with no clears, then restart from FAIL and time out again
    step(1'b1, 1'b0, 4'b0000, 4'b0000);
    idle_steps(TL + 3);
    step(1'b1, 1'b0, 4'b0000, 4'b0000);
    idle_steps(TL + 3);
    step(1'b0, 1'b1, 4'b0000, 4'b0000);

    // Stray clear/motor bits in stage 1, then the active puzzle's motor pulse
    step(1'b1, 1'b0, 4'b0000, 4'b0000);
    step(1'b0, 1'b0, 4'b0001, 4'b0000);
    idle_steps(HOLD);
    step(1'b0, 1'b0, 4'b1000, 4'b0001);
    step(1'b0, 1'b0, 4'b0100, 4'b1101);
    step(1'b0, 1'b0, 4'b0000, 4'b0010);
    idle_steps(2);
    step(1'b1, 1'b0, 4'b0000, 4'b0000);  // start ignored while running
    step(1'b0, 1'b1, 4'b0000, 4'b0000);

    // Clear on the last budget cycle wins over the timeout; budget then runs out
    step(1'b1, 1'b0, 4'b0000, 4'b0000);
    idle_steps(TL - 1);
    step(1'b0, 1'b0, 4'b0001, 4'b0000);
    idle_steps(HOLD + 3);
    step(1'b0, 1'b1, 4'b0000, 4'b0000);

    // Abort during HOLD; abort together with start
    step(1'b1, 1'b0, 4'b0000, 4'b0000);
    step(1'b0, 1'b0, 4'b0001, 4'b0000);
    idle_steps(2);
    step(1'b0, 1'b1, 4'b0000, 4'b0000);
    idle_steps(2);
    step(1'b1, 1'b1, 4'b0000, 4'b0000);
    idle_steps(2);

    // Asynchronous reset in the middle of RUN
    step(1'b1, 1'b0, 4'b0000, 4'b0000);
    idle_steps(3);
    mid_reset();
    idle_steps(2);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 19) == 0), ($urandom_range(0, 79) == 0),
           4'($urandom & $urandom), 4'($urandom));
    end
    idle_steps(2);
    @(negedge clk);
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
